// File: rtl/jtag_tap_oversampled.sv
// ============================================================================
//  Module      : jtag_tap_oversampled
//  Description : IEEE 1149.1 TAP controller with the JTAG pins oversampled
//                into the system clock domain. Nothing here is clocked by tck.
//                Implements the IR plus IDCODE, BYPASS and one USER data
//                register, with capture/update strobes toward debug logic.
//  Options     : JTAG_TAP_TRST_EN adds a synchronised trst_n input that
//                holds the TAP in Test-Logic-Reset while it is low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_tap_oversampled #(
    parameter int                  IR_WIDTH    = 5,
    parameter logic [31:0]         IDCODE_VAL  = 32'h1000_0A6F,
    parameter int                  USER_WIDTH  = 32,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [IR_WIDTH-1:0] USER_INSTR  = 5'h10
) (
    input  logic                  clkin,
    input  logic                  rst_n,
    input  logic                  tck,
    input  logic                  tms,
    input  logic                  tdi,
`ifdef JTAG_TAP_TRST_EN
    input  logic                  trst_n,
`endif
    output logic                  tdo,
    output logic [3:0]            tap_state,
    output logic [IR_WIDTH-1:0]   ir_value,
    output logic                  user_capture,
    input  logic [USER_WIDTH-1:0] user_capture_data,
    output logic                  user_update,
    output logic [USER_WIDTH-1:0] user_update_data
);

    // IDCODE opcode, also the instruction loaded in Test-Logic-Reset
    localparam logic [IR_WIDTH-1:0] c_IDCODE_OP  = {{(IR_WIDTH-1){1'b0}}, 1'b1};
    // Fixed pattern the IR captures so a scan chain can be sized/verified
    localparam logic [IR_WIDTH-1:0] c_IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, 2'b01};

    typedef enum logic [3:0] {
        ST_TLR   = 4'd0,  ST_RTI   = 4'd1,  ST_SELDR = 4'd2,  ST_CAPDR = 4'd3,
        ST_SHDR  = 4'd4,  ST_EX1DR = 4'd5,  ST_PAUDR = 4'd6,  ST_EX2DR = 4'd7,
        ST_UPDDR = 4'd8,  ST_SELIR = 4'd9,  ST_CAPIR = 4'd10, ST_SHIR  = 4'd11,
        ST_EX1IR = 4'd12, ST_PAUIR = 4'd13, ST_EX2IR = 4'd14, ST_UPDIR = 4'd15
    } tap_state_t;

    logic [SYNC_STAGES-1:0] r_tck_sync;
    logic [SYNC_STAGES-1:0] r_tms_sync;
    logic [SYNC_STAGES-1:0] r_tdi_sync;
    logic                   r_tck_prev;
    logic                   w_tck_s;
    logic                   w_tms_s;
    logic                   w_tdi_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_trst_active;

    tap_state_t             r_state;
    tap_state_t             w_state_next;

    logic [IR_WIDTH-1:0]    r_ir_shift;
    logic [31:0]            r_idcode_shift;
    logic [USER_WIDTH-1:0]  r_user_shift;
    logic                   r_bypass;
    logic                   w_sel_idcode;
    logic                   w_sel_user;
    logic                   w_dr_lsb;

    // Pin synchronisers; tms/tdi use the same depth as tck so they stay aligned
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_tck_sync <= '0;
            r_tms_sync <= '0;
            r_tdi_sync <= '0;
            r_tck_prev <= 1'b0;
        end else begin
            r_tck_sync <= {r_tck_sync[SYNC_STAGES-2:0], tck};
            r_tms_sync <= {r_tms_sync[SYNC_STAGES-2:0], tms};
            r_tdi_sync <= {r_tdi_sync[SYNC_STAGES-2:0], tdi};
            r_tck_prev <= r_tck_sync[SYNC_STAGES-1];
        end
    end

    assign w_tck_s = r_tck_sync[SYNC_STAGES-1];
    assign w_tms_s = r_tms_sync[SYNC_STAGES-1];
    assign w_tdi_s = r_tdi_sync[SYNC_STAGES-1];
    assign w_rise  =  w_tck_s & ~r_tck_prev;
    assign w_fall  = ~w_tck_s &  r_tck_prev;

`ifdef JTAG_TAP_TRST_EN
    logic [SYNC_STAGES-1:0] r_trst_sync;

    // trst_n synchroniser; resets low so the TAP stays held until it propagates
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_trst_sync <= '0;
        end else begin
            r_trst_sync <= {r_trst_sync[SYNC_STAGES-2:0], trst_n};
        end
    end

    assign w_trst_active = ~r_trst_sync[SYNC_STAGES-1];
`else
    assign w_trst_active = 1'b0;
`endif

    // DR selection from the active instruction; unknown opcodes fall to BYPASS
    assign w_sel_idcode = (ir_value == c_IDCODE_OP);
    assign w_sel_user   = (ir_value == USER_INSTR) && !w_sel_idcode;
    assign w_dr_lsb     = w_sel_idcode ? r_idcode_shift[0] :
                          w_sel_user   ? r_user_shift[0]   : r_bypass;

    // TAP state register
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_TLR;
        end else if (w_trst_active) begin
            r_state <= ST_TLR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Standard 1149.1 transition graph, advanced only on a recognised tck rise
    always_comb begin
        w_state_next = r_state;
        if (w_rise) begin
            case (r_state)
                ST_TLR:   w_state_next = w_tms_s ? ST_TLR   : ST_RTI;
                ST_RTI:   w_state_next = w_tms_s ? ST_SELDR : ST_RTI;
                ST_SELDR: w_state_next = w_tms_s ? ST_SELIR : ST_CAPDR;
                ST_CAPDR: w_state_next = w_tms_s ? ST_EX1DR : ST_SHDR;
                ST_SHDR:  w_state_next = w_tms_s ? ST_EX1DR : ST_SHDR;
                ST_EX1DR: w_state_next = w_tms_s ? ST_UPDDR : ST_PAUDR;
                ST_PAUDR: w_state_next = w_tms_s ? ST_EX2DR : ST_PAUDR;
                ST_EX2DR: w_state_next = w_tms_s ? ST_UPDDR : ST_SHDR;
                ST_UPDDR: w_state_next = w_tms_s ? ST_SELDR : ST_RTI;
                ST_SELIR: w_state_next = w_tms_s ? ST_TLR   : ST_CAPIR;
                ST_CAPIR: w_state_next = w_tms_s ? ST_EX1IR : ST_SHIR;
                ST_SHIR:  w_state_next = w_tms_s ? ST_EX1IR : ST_SHIR;
                ST_EX1IR: w_state_next = w_tms_s ? ST_UPDIR : ST_PAUIR;
                ST_PAUIR: w_state_next = w_tms_s ? ST_EX2IR : ST_PAUIR;
                ST_EX2IR: w_state_next = w_tms_s ? ST_UPDIR : ST_SHIR;
                ST_UPDIR: w_state_next = w_tms_s ? ST_SELDR : ST_RTI;
                default:  w_state_next = ST_TLR;
            endcase
        end
    end

    assign tap_state = r_state;

    // Capture and shift on tck rise, keyed on the state before the transition
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_ir_shift     <= '0;
            r_idcode_shift <= '0;
            r_user_shift   <= '0;
            r_bypass       <= 1'b0;
        end else if (w_rise) begin
            case (r_state)
                ST_CAPIR: r_ir_shift <= c_IR_CAPTURE;
                ST_SHIR:  r_ir_shift <= {w_tdi_s, r_ir_shift[IR_WIDTH-1:1]};
                ST_CAPDR: begin
                    if (w_sel_idcode)    r_idcode_shift <= IDCODE_VAL;
                    else if (w_sel_user) r_user_shift   <= user_capture_data;
                    else                 r_bypass       <= 1'b0;
                end
                ST_SHDR: begin
                    if (w_sel_idcode)    r_idcode_shift <= {w_tdi_s, r_idcode_shift[31:1]};
                    else if (w_sel_user) r_user_shift   <= {w_tdi_s, r_user_shift[USER_WIDTH-1:1]};
                    else                 r_bypass       <= w_tdi_s;
                end
                default: ;
            endcase
        end
    end

    // One-clkin capture strobe toward the USER register consumer
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            user_capture <= 1'b0;
        end else begin
            user_capture <= w_rise && !w_trst_active && (r_state == ST_CAPDR) && w_sel_user;
        end
    end

    // Falling-edge work: drive tdo, commit IR and USER updates
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            tdo              <= 1'b0;
            ir_value         <= c_IDCODE_OP;
            user_update      <= 1'b0;
            user_update_data <= '0;
        end else begin
            user_update <= 1'b0;
            if (w_trst_active) begin
                ir_value <= c_IDCODE_OP;
            end else if (w_fall) begin
                case (r_state)
                    ST_SHIR:  tdo <= r_ir_shift[0];
                    ST_SHDR:  tdo <= w_dr_lsb;
                    ST_UPDIR: ir_value <= r_ir_shift;
                    ST_TLR:   ir_value <= c_IDCODE_OP;
                    ST_UPDDR: begin
                        if (w_sel_user) begin
                            user_update_data <= r_user_shift;
                            user_update      <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jtag_tap_oversampled.sv
// ============================================================================
//  Module      : tb_jtag_tap_oversampled
//  Description : Directed self-checking bench for jtag_tap_oversampled.
//                Drives the JTAG pins slowly relative to clkin and checks
//                state, IR, tdo streams and USER strobes against
//                hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtag_tap_oversampled;

    logic        clkin = 1'b0;
    logic        rst_n = 1'b0;
    logic        tck   = 1'b0;
    logic        tms   = 1'b0;
    logic        tdi   = 1'b0;
    logic        tdo;
    logic [3:0]  tap_state;
    logic [4:0]  ir_value;
    logic        user_capture;
    logic [31:0] user_capture_data = 32'h0;
    logic        user_update;
    logic [31:0] user_update_data;
`ifdef JTAG_TAP_TRST_EN
    logic        trst_n = 1'b1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cap_cnt  = 0;
    int upd_cnt  = 0;

    jtag_tap_oversampled dut (
        .clkin             (clkin),
        .rst_n             (rst_n),
        .tck               (tck),
        .tms               (tms),
        .tdi               (tdi),
`ifdef JTAG_TAP_TRST_EN
        .trst_n            (trst_n),
`endif
        .tdo               (tdo),
        .tap_state         (tap_state),
        .ir_value          (ir_value),
        .user_capture      (user_capture),
        .user_capture_data (user_capture_data),
        .user_update       (user_update),
        .user_update_data  (user_update_data)
    );

    always #5 clkin = ~clkin;

    // Count strobe cycles so pulse counts can be compared
    always @(posedge clkin) begin
        if (user_capture) cap_cnt <= cap_cnt + 1;
        if (user_update)  upd_cnt <= upd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full tck period; returns tdo as seen just before the rising edge
    task automatic tck_pulse(input logic tms_v, input logic tdi_v, output logic tdo_s);
        @(negedge clkin);
        tms   = tms_v;
        tdi   = tdi_v;
        tdo_s = tdo;
        repeat (2) @(negedge clkin);
        tck = 1'b1;
        repeat (6) @(negedge clkin);
        tck = 1'b0;
        repeat (6) @(negedge clkin);
    endtask

    // RTI -> IR scan of v -> RTI; returns the bits shifted out LSB-first
    task automatic load_ir(input logic [4:0] v, output logic [4:0] cap);
        logic b;
        tck_pulse(1'b1, 1'b0, b);
        tck_pulse(1'b1, 1'b0, b);
        tck_pulse(1'b0, 1'b0, b);
        tck_pulse(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            tck_pulse(i == 4, v[i], b);
            cap[i] = b;
        end
        tck_pulse(1'b1, 1'b0, b);
        tck_pulse(1'b0, 1'b0, b);
    endtask

    // RTI -> n-bit DR scan of din -> RTI; returns the bits shifted out LSB-first
    task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic b;
        dout = 32'h0;
        tck_pulse(1'b1, 1'b0, b);
        tck_pulse(1'b0, 1'b0, b);
        tck_pulse(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            tck_pulse(i == n - 1, din[i], b);
            dout[i] = b;
        end
        tck_pulse(1'b1, 1'b0, b);
        tck_pulse(1'b0, 1'b0, b);
    endtask

    initial begin
        logic        b;
        logic [4:0]  irc;
        logic [31:0] dout;

        repeat (5) @(negedge clkin);
        rst_n = 1'b1;
        repeat (5) @(negedge clkin);

        // Reset state with tck idle low
        check("rst_state",  32'(tap_state), 32'd0);
        check("rst_ir",     32'(ir_value), 32'h01);
        check("rst_tdo",    32'(tdo), 32'd0);
        check("rst_updata", user_update_data, 32'h0);
        check("rst_strobe", 32'(cap_cnt + upd_cnt), 32'd0);

        // TLR -> RTI, then five tms=1 rises back to TLR
        tck_pulse(1'b0, 1'b0, b);
        check("rti_state", 32'(tap_state), 32'd1);
        tck_pulse(1'b1, 1'b0, b);
        check("seldr_state", 32'(tap_state), 32'd2);
        tck_pulse(1'b1, 1'b0, b);
        check("selir_state", 32'(tap_state), 32'd9);
        for (int i = 0; i < 3; i++) tck_pulse(1'b1, 1'b0, b);
        check("tlr5_state", 32'(tap_state), 32'd0);
        check("tlr5_ir",    32'(ir_value), 32'h01);

        // IDCODE readout
        tck_pulse(1'b0, 1'b0, b);
        shift_dr(32, 32'h0, dout);
        check("idcode", dout, 32'h1000_0A6F);
        check("idcode_rti", 32'(tap_state), 32'd1);

        // BYPASS: IR capture pattern, then pattern 1,0,1,1 comes out one tck late
        load_ir(5'h1F, irc);
        check("ir_capture", 32'(irc), 32'h01);
        check("ir_bypass",  32'(ir_value), 32'h1F);
        shift_dr(4, 32'hD, dout);
        check("bypass_out", dout, 32'hA);
        check("bypass_nostrobe", 32'(cap_cnt + upd_cnt), 32'd0);

        // tms reset returns the IR to IDCODE
        for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0, b);
        check("tlr_ir_restore", 32'(ir_value), 32'h01);
        tck_pulse(1'b0, 1'b0, b);

        // USER register round trip
        load_ir(5'h10, irc);
        check("ir_user", 32'(ir_value), 32'h10);
        user_capture_data = 32'hCAFE_F00D;
        shift_dr(32, 32'h1234_5678, dout);
        check("user_out",     dout, 32'hCAFE_F00D);
        check("user_cap_cnt", 32'(cap_cnt), 32'd1);
        check("user_upd_cnt", 32'(upd_cnt), 32'd1);
        check("user_updata",  user_update_data, 32'h1234_5678);

        // Reset in the middle of a USER shift
        user_capture_data = 32'h5555_AAAA;
        tck_pulse(1'b1, 1'b0, b);
        tck_pulse(1'b0, 1'b0, b);
        tck_pulse(1'b0, 1'b0, b);
        check("mid_shdr", 32'(tap_state), 32'd4);
        for (int i = 0; i < 10; i++) tck_pulse(1'b0, 1'b1, b);
        @(negedge clkin);
        rst_n = 1'b0;
        #1;
        check("midrst_state", 32'(tap_state), 32'd0);
        check("midrst_ir",    32'(ir_value), 32'h01);
        repeat (3) @(negedge clkin);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tck_pulse(1'b1, 1'b0, b);
        check("midrst_tlr",    32'(tap_state), 32'd0);
        check("midrst_upd",    32'(upd_cnt), 32'd1);
        check("midrst_cap",    32'(cap_cnt), 32'd2);
        check("midrst_updata", user_update_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
